// File: rtl/icache_ctrl_nway.sv
// icache_ctrl_nway: N-way set-associative instruction cache controller.
// Parallel tag lookup over all ways, single-line AXI4 INCR refill on a miss,
// lowest-invalid-then-true-LRU replacement, runtime flush and bus-error reporting.
module icache_ctrl_nway #(
  parameter  int ADDR_SIZE      = 32,
  parameter  int WAYS           = 4,
  parameter  int SETS           = 64,
  parameter  int WORDS_PER_LINE = 8,
  parameter  int INST_SIZE      = 32,
  localparam int OFS            = 2,
  localparam int WB             = $clog2(WORDS_PER_LINE),
  localparam int IB             = $clog2(SETS),
  localparam int TB             = ADDR_SIZE - IB - WB - OFS,
  localparam int LINE_W         = 1 + TB + WORDS_PER_LINE * 32
) (
  input  logic                   i_clk,
  input  logic                   i_areset_n,
  input  logic                   i_req,
  input  logic [ADDR_SIZE-1:0]   i_addr,
  input  logic                   i_flush,
  output logic                   o_ready,
  output logic                   o_instr_valid,
  output logic [INST_SIZE-1:0]   o_instruction,
  output logic                   o_err,
  output logic [IB-1:0]          o_ram_addr,
  output logic [WAYS-1:0]        o_ram_we,
  output logic [LINE_W-1:0]      o_ram_wline,
  input  logic [WAYS*LINE_W-1:0] i_ram_rline,
  output logic                   o_arvalid,
  input  logic                   i_arready,
  output logic [ADDR_SIZE-1:0]   o_araddr,
  output logic [7:0]             o_arlen,
  output logic [2:0]             o_arsize,
  output logic [1:0]             o_arburst,
  input  logic                   i_rvalid,
  output logic                   o_rready,
  input  logic [31:0]            i_rdata,
  input  logic [1:0]             i_rresp,
  input  logic                   i_rlast
);

  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_LOOKUP, S_AR, S_RD, S_FILL
  } state_t;

  state_t state, state_nx;

  logic [IB-1:0]                        counter;
  logic [TB-1:0]                        req_tag;
  logic [IB-1:0]                        req_idx;
  logic [WB-1:0]                        req_word;
  logic                                 flush_pend;
  logic [AW-1:0]                        victim;
  logic [WB-1:0]                        beat;
  logic                                 err;
  logic [WORDS_PER_LINE-1:0][31:0]      buffer;
  logic [AW-1:0]                        age [SETS][WAYS];

  logic                                 hit;
  logic [AW-1:0]                        hit_way;
  logic [31:0]                          hit_word;
  logic                                 inv_found;
  logic [AW-1:0]                        inv_way;
  logic [AW-1:0]                        lru_victim;
  logic [AW-1:0]                        victim_nx;
  logic [LINE_W-1:0]                    way_line;
  logic                                 lru_upd;
  logic [AW-1:0]                        lru_way;
  logic                                 unused_addr_bits;

  assign unused_addr_bits = ^i_addr[OFS-1:0];

  assign o_araddr  = {req_tag, req_idx, {(WB + OFS){1'b0}}};
  assign o_arlen   = 8'(WORDS_PER_LINE - 1);
  assign o_arsize  = 3'd2;
  assign o_arburst = 2'b01;

  // Compare every way's line against the captured tag; also pick the refill victim.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    hit_word   = '0;
    inv_found  = 1'b0;
    inv_way    = '0;
    lru_victim = '0;
    way_line   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_line = i_ram_rline[w*LINE_W +: LINE_W];
      if (!way_line[LINE_W-1]) begin
        inv_found = 1'b1;
        inv_way   = AW'(w);
      end
      if (age[req_idx][w] == AW'(WAYS - 1)) begin
        lru_victim = AW'(w);
      end
      if (way_line[LINE_W-1] && (way_line[LINE_W-2 -: TB] == req_tag)) begin
        hit      = 1'b1;
        hit_way  = AW'(w);
        hit_word = way_line[int'(req_word)*32 +: 32];
      end
    end
    victim_nx = inv_found ? inv_way : lru_victim;
  end

  // Next-state and output decode for the controller FSM.
  always_comb begin
    state_nx      = state;
    o_ready       = 1'b0;
    o_instr_valid = 1'b0;
    o_instruction = '0;
    o_err         = 1'b0;
    o_ram_addr    = req_idx;
    o_ram_we      = '0;
    o_ram_wline   = '0;
    o_arvalid     = 1'b0;
    o_rready      = 1'b0;
    lru_upd       = 1'b0;
    lru_way       = hit_way;
    case (state)
      S_FLUSH: begin
        o_ram_addr = counter;
        if (i_areset_n) begin
          o_ram_we = '1;
        end
        if (counter == IB'(SETS - 1)) begin
          state_nx = S_IDLE;
        end
      end
      S_IDLE: begin
        o_ready    = ~i_flush & ~flush_pend;
        o_ram_addr = i_addr[IB+WB+OFS-1 -: IB];
        if (i_flush || flush_pend) begin
          state_nx = S_FLUSH;
        end else if (i_req) begin
          state_nx = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          o_instr_valid = 1'b1;
          o_instruction = hit_word;
          lru_upd       = 1'b1;
          state_nx      = S_IDLE;
        end else begin
          state_nx = S_AR;
        end
      end
      S_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) begin
          state_nx = S_RD;
        end
      end
      S_RD: begin
        o_rready = 1'b1;
        if (i_rvalid && i_rlast) begin
          state_nx = S_FILL;
        end
      end
      S_FILL: begin
        o_instr_valid = 1'b1;
        o_instruction = buffer[req_word];
        if (err) begin
          o_err = 1'b1;
        end else begin
          o_ram_we    = WAYS'(1) << victim;
          o_ram_wline = {1'b1, req_tag, buffer};
          lru_upd     = 1'b1;
          lru_way     = victim;
        end
        state_nx = S_IDLE;
      end
      default: state_nx = S_FLUSH;
    endcase
  end

  // Control registers: state, flush counter, captured request, burst bookkeeping.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state      <= S_FLUSH;
      counter    <= '0;
      req_tag    <= '0;
      req_idx    <= '0;
      req_word   <= '0;
      flush_pend <= 1'b0;
      victim     <= '0;
      beat       <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FLUSH) begin
        counter <= counter + 1'b1;
      end
      if (state == S_IDLE) begin
        flush_pend <= 1'b0;
      end else if (i_flush && state != S_FLUSH) begin
        flush_pend <= 1'b1;
      end
      if (o_ready && i_req) begin
        req_tag  <= i_addr[ADDR_SIZE-1 -: TB];
        req_idx  <= i_addr[IB+WB+OFS-1 -: IB];
        req_word <= i_addr[WB+OFS-1 -: WB];
      end
      if (state == S_LOOKUP) begin
        victim <= victim_nx;
        beat   <= '0;
        err    <= 1'b0;
      end
      if (state == S_RD && i_rvalid) begin
        beat <= beat + 1'b1;
        if (i_rresp != 2'b00 || (i_rlast && beat != WB'(WORDS_PER_LINE - 1))) begin
          err <= 1'b1;
        end
      end
    end
  end

  // Refill buffer collects each accepted beat at its position in the line.
  always_ff @(posedge i_clk) begin
    if (state == S_RD && i_rvalid) begin
      buffer[beat] <= i_rdata;
    end
  end

  // LRU ages: reseeded while flushing, otherwise the accessed way becomes youngest.
  always_ff @(posedge i_clk) begin
    if (state == S_FLUSH) begin
      for (int w = 0; w < WAYS; w++) begin
        age[counter][w] <= AW'(w);
      end
    end else if (lru_upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == lru_way) begin
          age[req_idx][w] <= '0;
        end else if (age[req_idx][w] < age[req_idx][lru_way]) begin
          age[req_idx][w] <= age[req_idx][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// tb_icache_ctrl_nway: self-checking bench with way-RAM model, AXI read slave
// and a response scoreboard for icache_ctrl_nway.
module tb_icache_ctrl_nway;

  localparam int ADDR_SIZE = 32;
  localparam int WAYS      = 4;
  localparam int SETS      = 64;
  localparam int WPL       = 8;
  localparam int IB        = 6;
  localparam int LINE_W    = 1 + 21 + WPL * 32;

  logic                   i_clk;
  logic                   i_areset_n;
  logic                   i_req;
  logic [ADDR_SIZE-1:0]   i_addr;
  logic                   i_flush;
  logic                   o_ready;
  logic                   o_instr_valid;
  logic [31:0]            o_instruction;
  logic                   o_err;
  logic [IB-1:0]          o_ram_addr;
  logic [WAYS-1:0]        o_ram_we;
  logic [LINE_W-1:0]      o_ram_wline;
  logic [WAYS*LINE_W-1:0] i_ram_rline;
  logic                   o_arvalid;
  logic                   i_arready;
  logic [ADDR_SIZE-1:0]   o_araddr;
  logic [7:0]             o_arlen;
  logic [2:0]             o_arsize;
  logic [1:0]             o_arburst;
  logic                   i_rvalid;
  logic                   o_rready;
  logic [31:0]            i_rdata;
  logic [1:0]             i_rresp;
  logic                   i_rlast;

  icache_ctrl_nway dut (
    .i_clk         (i_clk),
    .i_areset_n    (i_areset_n),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_flush       (i_flush),
    .o_ready       (o_ready),
    .o_instr_valid (o_instr_valid),
    .o_instruction (o_instruction),
    .o_err         (o_err),
    .o_ram_addr    (o_ram_addr),
    .o_ram_we      (o_ram_we),
    .o_ram_wline   (o_ram_wline),
    .i_ram_rline   (i_ram_rline),
    .o_arvalid     (o_arvalid),
    .i_arready     (i_arready),
    .o_araddr      (o_araddr),
    .o_arlen       (o_arlen),
    .o_arsize      (o_arsize),
    .o_arburst     (o_arburst),
    .i_rvalid      (i_rvalid),
    .o_rready      (o_rready),
    .i_rdata       (i_rdata),
    .i_rresp       (i_rresp),
    .i_rlast       (i_rlast)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    int          exp_way;
  } vec_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  resp_t        resp_q[$];
  logic [31:0]  ar_exp_q[$];
  int           fill_count = 0;
  logic [3:0]   last_fill_we = '0;

  int           ar_delay  = 0;
  int           err_beat  = -1;
  bit           gap_mode  = 0;
  int           last_burst_beats = 0;
  int           last_ar_cycles   = 0;

  logic [LINE_W-1:0] mem [WAYS][SETS];

  // Free-running 10 ns clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Backing memory content: each word is its own address tagged with a marker.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Per-way line RAMs with one-cycle synchronous read.
  always @(posedge i_clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (o_ram_we[w]) mem[w][o_ram_addr] <= o_ram_wline;
      i_ram_rline[w*LINE_W +: LINE_W] <= mem[w][o_ram_addr];
    end
  end

  // Response scoreboard and refill-write observer.
  always @(negedge i_clk) begin
    if (i_areset_n && o_instr_valid) begin
      if (resp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_resp: got data 0x%08h, expected no response", o_instruction);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        checkOutput("resp_err", 32'(o_err), 32'(r.err));
        if (!r.err) checkOutput("resp_data", o_instruction, r.data);
      end
    end
    if (i_areset_n && o_ram_we != '0 && o_ram_wline[LINE_W-1]) begin
      fill_count++;
      last_fill_we = o_ram_we;
    end
  end

  // AXI read slave: optional AR delay, optional one-cycle gap before each beat, optional SLVERR beat.
  initial begin : axi_slave
    int          ar_cnt;
    int          beat_idx;
    int          beats_seen;
    bit          rbusy;
    bit          ar_hs_q;
    bit          r_hs_q;
    bit          gap_done;
    bit          ar_hold_v;
    logic [31:0] ar_hold;
    logic [31:0] burst_addr;
    i_arready = 0; i_rvalid = 0; i_rdata = '0; i_rresp = '0; i_rlast = 0;
    ar_cnt = 0; beat_idx = 0; beats_seen = 0; rbusy = 0; ar_hs_q = 0; r_hs_q = 0;
    gap_done = 0; ar_hold_v = 0; ar_hold = '0; burst_addr = '0;
    forever begin
      @(negedge i_clk);
      if (!i_areset_n) begin
        i_arready = 0; i_rvalid = 0; i_rlast = 0;
        rbusy = 0; ar_hs_q = 0; r_hs_q = 0; ar_cnt = 0; ar_hold_v = 0; gap_done = 0;
        continue;
      end
      if (ar_hs_q) begin
        rbusy = 1; beat_idx = 0; beats_seen = 0; ar_hold_v = 0;
        last_ar_cycles = ar_cnt + 1; ar_cnt = 0;
      end
      if (r_hs_q) begin
        beats_seen++;
        beat_idx++;
        if (i_rlast) begin
          rbusy = 0;
          last_burst_beats = beats_seen;
        end
      end
      i_arready = 0;
      if (!rbusy && !ar_hs_q && o_arvalid) begin
        if (ar_hold_v) checkOutput("araddr_stable", o_araddr, ar_hold);
        else begin
          ar_hold = o_araddr;
          ar_hold_v = 1;
        end
        if (ar_cnt >= ar_delay) begin
          i_arready = 1;
          burst_addr = o_araddr;
          if (ar_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_ar: got araddr 0x%08h, expected no AR", o_araddr);
          end else begin
            checkOutput("araddr", o_araddr, ar_exp_q.pop_front());
          end
          checkOutput("arlen", 32'(o_arlen), 32'd7);
          checkOutput("arsize", 32'(o_arsize), 32'd2);
          checkOutput("arburst", 32'(o_arburst), 32'd1);
        end else begin
          ar_cnt++;
        end
      end
      if (!rbusy) begin
        i_rvalid = 0;
        i_rlast = 0;
      end else if (!(i_rvalid && !r_hs_q)) begin
        if (gap_mode && !gap_done) begin
          i_rvalid = 0;
          gap_done = 1;
        end else begin
          gap_done = 0;
          i_rvalid = 1;
          i_rdata  = mem_word(burst_addr + 32'(4 * beat_idx));
          i_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
          i_rlast  = (beat_idx == WPL - 1);
        end
      end
      ar_hs_q = i_arready && o_arvalid;
      r_hs_q  = i_rvalid && o_rready;
    end
  end

  // Issue one fetch, queue its expected response and wait for it; returns one cycle after the response.
  task automatic applyStimulus(input logic [31:0] addr, input bit exp_err, input bit exp_hit, output int lat);
    int k;
    resp_t r;
    k = 0;
    @(negedge i_clk);
    while (!o_ready && k < 300) begin
      @(negedge i_clk);
      k++;
    end
    if (!o_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ready_timeout: got o_ready 0 for addr 0x%08h, expected 1", addr);
      lat = -1;
      return;
    end
    i_req  = 1;
    i_addr = addr;
    r.data = mem_word(addr);
    r.err  = exp_err;
    resp_q.push_back(r);
    if (!exp_hit) ar_exp_q.push_back({addr[31:5], 5'b0});
    lat = 0;
    do begin
      @(negedge i_clk);
      i_req = 0;
      lat++;
    end while (!o_instr_valid && lat < 300);
    if (!o_instr_valid) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL resp_timeout: got no o_instr_valid for addr 0x%08h, expected a response", addr);
    end
    @(negedge i_clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin : main
    vec_t vecs[12];
    int   lat;
    int   cnt;
    int   k;
    int   fills_before;
    bit   addr_ok;

    vecs[0]  = '{32'h0000_1000, 1'b0, 0};
    vecs[1]  = '{32'h0000_1004, 1'b1, -1};
    vecs[2]  = '{32'h0000_101C, 1'b1, -1};
    vecs[3]  = '{32'h0000_1800, 1'b0, 1};
    vecs[4]  = '{32'h0000_2000, 1'b0, 2};
    vecs[5]  = '{32'h0000_2800, 1'b0, 3};
    vecs[6]  = '{32'h0000_1008, 1'b1, -1};
    vecs[7]  = '{32'h0000_3000, 1'b0, 1};
    vecs[8]  = '{32'h0000_1800, 1'b0, 2};
    vecs[9]  = '{32'h0000_3004, 1'b1, -1};
    vecs[10] = '{32'h0000_0020, 1'b0, 0};
    vecs[11] = '{32'h0000_0024, 1'b1, -1};

    i_areset_n = 0;
    i_req = 0;
    i_addr = '0;
    i_flush = 0;
    repeat (3) @(negedge i_clk);
    checkOutput("rst_ready", 32'(o_ready), 0);
    checkOutput("rst_instr_valid", 32'(o_instr_valid), 0);
    checkOutput("rst_err", 32'(o_err), 0);
    checkOutput("rst_arvalid", 32'(o_arvalid), 0);
    checkOutput("rst_rready", 32'(o_rready), 0);
    checkOutput("rst_ram_we", 32'(o_ram_we), 0);

    @(posedge i_clk);
    #2 i_areset_n = 1;
    cnt = 0;
    k = 0;
    addr_ok = 1;
    @(negedge i_clk);
    while (!o_ready && k < 300) begin
      if (o_ram_we == 4'hF) begin
        if (o_ram_addr != IB'(cnt)) addr_ok = 0;
        cnt++;
      end
      @(negedge i_clk);
      k++;
    end
    checkOutput("init_flush_cycles", cnt, 64);
    checkOutput("init_flush_addrs", 32'(addr_ok), 1);

    for (int i = 0; i < 12; i++) begin
      fills_before = fill_count;
      applyStimulus(vecs[i].addr, 1'b0, vecs[i].exp_hit, lat);
      checkOutput($sformatf("hit_%0d", i), 32'(lat == 1), 32'(vecs[i].exp_hit));
      if (!vecs[i].exp_hit) begin
        checkOutput($sformatf("fill_way_%0d", i), 32'(last_fill_we), 32'(4'b0001 << vecs[i].exp_way));
        checkOutput($sformatf("beats_%0d", i), last_burst_beats, 8);
      end else begin
        checkOutput($sformatf("no_fill_%0d", i), fill_count, fills_before);
      end
    end

    err_beat = 3;
    fills_before = fill_count;
    applyStimulus(32'h0000_4040, 1'b1, 1'b0, lat);
    checkOutput("err_no_write", fill_count, fills_before);
    checkOutput("err_beats", last_burst_beats, 8);
    err_beat = -1;
    applyStimulus(32'h0000_4040, 1'b0, 1'b0, lat);
    checkOutput("err_rerequest_miss", 32'(lat > 1), 1);
    checkOutput("err_rerequest_fill", fill_count, fills_before + 1);

    fork
      applyStimulus(32'h0000_5000, 1'b0, 1'b0, lat);
      begin
        int j;
        j = 0;
        while (!o_rready && j < 300) begin
          @(negedge i_clk);
          j++;
        end
        i_flush = 1;
        @(negedge i_clk);
        i_flush = 0;
      end
    join
    cnt = 0;
    k = 0;
    while (!o_ready && k < 300) begin
      if (o_ram_we == 4'hF) cnt++;
      @(negedge i_clk);
      k++;
    end
    checkOutput("rd_flush_cycles", cnt, 64);
    applyStimulus(32'h0000_1000, 1'b0, 1'b0, lat);
    checkOutput("after_flush_miss", 32'(lat > 1), 1);
    checkOutput("after_flush_way", 32'(last_fill_we), 32'h1);

    k = 0;
    @(negedge i_clk);
    while (!o_ready && k < 300) begin
      @(negedge i_clk);
      k++;
    end
    i_req = 1;
    i_addr = 32'h0000_1004;
    i_flush = 1;
    #1 checkOutput("flush_blocks_ready", 32'(o_ready), 0);
    @(negedge i_clk);
    i_req = 0;
    i_flush = 0;
    cnt = 0;
    k = 0;
    while (!o_ready && k < 300) begin
      if (o_ram_we == 4'hF) cnt++;
      @(negedge i_clk);
      k++;
    end
    checkOutput("idle_flush_cycles", cnt, 64);
    applyStimulus(32'h0000_1004, 1'b0, 1'b0, lat);
    checkOutput("idle_flush_miss", 32'(lat > 1), 1);

    ar_delay = 5;
    applyStimulus(32'h0000_6000, 1'b0, 1'b0, lat);
    checkOutput("ar_wait_cycles", last_ar_cycles, 6);
    ar_delay = 0;

    gap_mode = 1;
    applyStimulus(32'h0000_681C, 1'b0, 1'b0, lat);
    checkOutput("gap_beats", last_burst_beats, 8);
    gap_mode = 0;
    applyStimulus(32'h0000_6808, 1'b0, 1'b1, lat);
    checkOutput("gap_hit_w2", 32'(lat == 1), 1);
    applyStimulus(32'h0000_6800, 1'b0, 1'b1, lat);
    checkOutput("gap_hit_w0", 32'(lat == 1), 1);

    repeat (3) @(negedge i_clk);
    checkOutput("resp_q_empty", resp_q.size(), 0);
    checkOutput("ar_q_empty", ar_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
